// File: rtl/armleocpu_simple2axi_converter.sv
// Bridge from a single-outstanding simple request port to AXI4 single-beat transactions.
// Every transfer is one 32-bit INCR beat; all non-constant outputs are registered.
module armleocpu_simple2axi_converter #(
  parameter int unsigned ADDR_WIDTH     = 34,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TRANSACTION_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_byteenable,
  output logic                  done,
  output logic [31:0]           read_data,
  output logic [1:0]            response,

  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,

  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,

  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  input  logic [ID_WIDTH-1:0]   axi_bid,

  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,

  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [ID_WIDTH-1:0]   axi_rid
);

  localparam logic [2:0] STATE_IDLE            = 3'd0;
  localparam logic [2:0] STATE_WRITE_ADDR_DATA = 3'd1;
  localparam logic [2:0] STATE_WRITE_RESP      = 3'd2;
  localparam logic [2:0] STATE_READ_ADDR       = 3'd3;
  localparam logic [2:0] STATE_READ_RESP       = 3'd4;
  localparam logic [2:0] STATE_DONE            = 3'd5;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  done_q, done_d;
  logic [31:0]           read_data_q, read_data_d;
  logic [1:0]            response_q, response_d;

  // A channel counts as finished if it already handshook or handshakes at this edge.
  logic aw_finished, w_finished;
  assign aw_finished = !awvalid_q || axi_awready;
  assign w_finished  = !wvalid_q || axi_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    done_d      = 1'b0;
    read_data_d = read_data_q;
    response_d  = response_q;

    case (state_q)
      STATE_IDLE: begin
        if (write) begin
          addr_d    = address;
          wdata_d   = write_data;
          wstrb_d   = write_byteenable;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = STATE_WRITE_ADDR_DATA;
        end else if (read) begin
          addr_d    = address;
          arvalid_d = 1'b1;
          state_d   = STATE_READ_ADDR;
        end
      end
      STATE_WRITE_ADDR_DATA: begin
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_finished && w_finished) begin
          bready_d = 1'b1;
          state_d  = STATE_WRITE_RESP;
        end
      end
      STATE_WRITE_RESP: begin
        if (axi_bvalid) begin
          response_d = axi_bresp;
          bready_d   = 1'b0;
          done_d     = 1'b1;
          state_d    = STATE_DONE;
        end
      end
      STATE_READ_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = STATE_READ_RESP;
        end
      end
      STATE_READ_RESP: begin
        if (axi_rvalid) begin
          read_data_d = axi_rdata;
          // A multi-beat answer to a single-beat request is reported as a slave error.
          response_d  = axi_rlast ? axi_rresp : RESP_SLVERR;
          rready_d    = 1'b0;
          done_d      = 1'b1;
          state_d     = STATE_DONE;
        end
      end
      STATE_DONE: begin
        state_d = STATE_IDLE;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 1'b0;
      read_data_q <= '0;
      response_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
      response_q  <= response_d;
    end
  end

  assign done      = done_q;
  assign read_data = read_data_q;
  assign response  = response_q;

  assign axi_awvalid = awvalid_q;
  assign axi_awid    = ID_WIDTH'(TRANSACTION_ID);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'd2;
  assign axi_awburst = 2'b01;

  assign axi_wvalid = wvalid_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_wlast  = 1'b1;

  assign axi_bready = bready_q;

  assign axi_arvalid = arvalid_q;
  assign axi_arid    = ID_WIDTH'(TRANSACTION_ID);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'd2;
  assign axi_arburst = 2'b01;

  assign axi_rready = rready_q;

  // Single outstanding transaction with a fixed ID, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{axi_bid, axi_rid};

endmodule

// File: tb/tb_armleocpu_simple2axi_converter.sv
// Randomized bench for the simple-to-AXI master bridge with a cycle-level transaction model.
module tb_armleocpu_simple2axi_converter;

  logic        clk;
  logic        rst;
  logic [33:0] address;
  logic        write;
  logic        read;
  logic [31:0] write_data;
  logic [3:0]  write_byteenable;
  logic        done;
  logic [31:0] read_data;
  logic [1:0]  response;

  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_awid;
  logic [33:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_arid;
  logic [33:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_rdata;

  armleocpu_simple2axi_converter #(
    .ADDR_WIDTH    (34),
    .ID_WIDTH      (4),
    .TRANSACTION_ID(0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .write           (write),
    .read            (read),
    .write_data      (write_data),
    .write_byteenable(write_byteenable),
    .done            (done),
    .read_data       (read_data),
    .response        (response),
    .axi_awvalid     (axi_awvalid),
    .axi_awready     (axi_awready),
    .axi_awid        (axi_awid),
    .axi_awaddr      (axi_awaddr),
    .axi_awlen       (axi_awlen),
    .axi_awsize      (axi_awsize),
    .axi_awburst     (axi_awburst),
    .axi_wvalid      (axi_wvalid),
    .axi_wready      (axi_wready),
    .axi_wdata       (axi_wdata),
    .axi_wstrb       (axi_wstrb),
    .axi_wlast       (axi_wlast),
    .axi_bvalid      (axi_bvalid),
    .axi_bready      (axi_bready),
    .axi_bresp       (axi_bresp),
    .axi_bid         (axi_bid),
    .axi_arvalid     (axi_arvalid),
    .axi_arready     (axi_arready),
    .axi_arid        (axi_arid),
    .axi_araddr      (axi_araddr),
    .axi_arlen       (axi_arlen),
    .axi_arsize      (axi_arsize),
    .axi_arburst     (axi_arburst),
    .axi_rvalid      (axi_rvalid),
    .axi_rready      (axi_rready),
    .axi_rdata       (axi_rdata),
    .axi_rresp       (axi_rresp),
    .axi_rlast       (axi_rlast),
    .axi_rid         (axi_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle c counts from 1 = first cycle after the edge that accepted the request.
  // Write model: AW valid for aw_d+1 cycles, W for w_d+1, B wait b_d, done at max+b_d+3.
  task automatic do_write(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int aw_d, input int w_d, input int b_d, input logic [1:0] bresp,
                          input logic also_read);
    int wp, exp_done, done_c, bad;
    wp       = ((aw_d > w_d) ? aw_d : w_d) + 1;
    exp_done = wp + b_d + 2;
    done_c   = 0;
    bad      = 0;
    address = a; write_data = d; write_byteenable = be; write = 1'b1; read = also_read;
    @(posedge clk); #1;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      bad += int'(axi_awvalid != (c <= aw_d + 1));
      bad += int'(axi_wvalid != (c <= w_d + 1));
      bad += int'(axi_bready != (c > wp && c <= wp + b_d + 1));
      bad += int'(axi_arvalid) + int'(axi_rready);
      bad += int'(done != (c == exp_done));
      if (axi_awvalid)
        bad += int'({axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst} !=
                    {a, 4'd0, 8'd0, 3'd2, 2'b01});
      if (axi_wvalid)
        bad += int'({axi_wdata, axi_wstrb, axi_wlast} != {d, be, 1'b1});
      if (done) begin
        done_c = c;
        write  = 1'b0;
        read   = 1'b0;
      end
      axi_awready = (c == aw_d + 1);
      axi_wready  = (c == w_d + 1);
      axi_bvalid  = (c >= wp + b_d + 1) && (done_c == 0);
      axi_bresp   = axi_bvalid ? bresp : 2'($urandom);
      axi_bid     = 4'($urandom);
      @(posedge clk); #1;
    end
    axi_bvalid = 1'b0;
    check_val("wr_sequence", 64'(bad), 64'd0);
    check_val("wr_done_latency", 64'(done_c), 64'(exp_done));
    check_val("wr_response", 64'(response), 64'(bresp));
    check_val("wr_read_data_hold", 64'(read_data), 64'(exp_rdata));
    check_val("wr_done_one_cycle", 64'(done), 64'd0);
  endtask

  // Read model: AR valid for ar_d+1 cycles, R wait r_d, done at ar_d+r_d+3.
  task automatic do_read(input logic [33:0] a, input int ar_d, input int r_d,
                         input logic [31:0] rd, input logic [1:0] rr, input logic rl);
    int arp, exp_done, done_c, bad;
    logic [1:0] exp_resp;
    arp      = ar_d + 1;
    exp_done = arp + r_d + 2;
    exp_resp = rl ? rr : 2'b10;
    done_c   = 0;
    bad      = 0;
    address = a; write = 1'b0; read = 1'b1;
    write_data = $urandom; write_byteenable = 4'($urandom);
    @(posedge clk); #1;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      bad += int'(axi_arvalid != (c <= arp));
      bad += int'(axi_rready != (c > arp && c <= arp + r_d + 1));
      bad += int'(axi_awvalid) + int'(axi_wvalid) + int'(axi_bready);
      bad += int'(done != (c == exp_done));
      if (axi_arvalid)
        bad += int'({axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst} !=
                    {a, 4'd0, 8'd0, 3'd2, 2'b01});
      if (done) begin
        done_c = c;
        read   = 1'b0;
      end
      axi_arready = (c == arp);
      axi_rvalid  = (c >= arp + r_d + 1) && (done_c == 0);
      axi_rdata   = axi_rvalid ? rd : $urandom;
      axi_rresp   = axi_rvalid ? rr : 2'($urandom);
      axi_rlast   = axi_rvalid ? rl : 1'($urandom);
      axi_rid     = 4'($urandom);
      @(posedge clk); #1;
    end
    axi_rvalid = 1'b0;
    exp_rdata  = rd;
    check_val("rd_sequence", 64'(bad), 64'd0);
    check_val("rd_done_latency", 64'(done_c), 64'(exp_done));
    check_val("rd_read_data", 64'(read_data), 64'(rd));
    check_val("rd_response", 64'(response), 64'(exp_resp));
    check_val("rd_done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] tmp;
    logic [33:0] a;
    logic [31:0] d;
    n_checks = 0;
    n_fail   = 0;
    exp_rdata = 32'd0;
    rst = 1'b1;
    address = '0; write = 1'b0; read = 1'b0; write_data = '0; write_byteenable = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0; axi_bid = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
    axi_rid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_handshakes",
              64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, done}), 64'd0);
    check_val("reset_read_data", 64'(read_data), 64'd0);
    check_val("reset_response", 64'(response), 64'd0);
    rst = 1'b0;

    // Directed cases
    do_read(34'h100, 0, 0, 32'hDEADBEEF, 2'b00, 1'b1);
    do_write(34'h2_0000_0040, 32'h12345678, 4'b0011, 0, 3, 1, 2'b00, 1'b0);
    do_read(34'h3_FFFF_FFFC, 5, 0, 32'hCAFEF00D, 2'b00, 1'b1);
    do_write(34'h44, 32'hA5A5A5A5, 4'b1111, 2, 0, 0, 2'b11, 1'b0);
    do_read(34'h48, 0, 2, 32'h0BADF00D, 2'b00, 1'b0);
    do_write(34'h1_0000_0000, 32'h5A5A5A5A, 4'b1000, 1, 1, 2, 2'b01, 1'b1);

    // Reset while AW/W are pending abandons the write
    address = 34'h80; write_data = 32'h11111111; write_byteenable = 4'hF; write = 1'b1;
    @(posedge clk); #1;
    check_val("mid_reset_awvalid_before", 64'(axi_awvalid), 64'd1);
    rst = 1'b1;
    write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_reset_handshakes",
              64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, done}), 64'd0);
    check_val("mid_reset_read_data", 64'(read_data), 64'd0);
    check_val("mid_reset_response", 64'(response), 64'd0);
    exp_rdata = 32'd0;
    do_read(34'h84, 1, 1, 32'h76543210, 2'b00, 1'b1);

    // Randomized mix of reads and writes with random slave stalls
    for (int i = 0; i < 40; i++) begin
      tmp = {$urandom, $urandom};
      a   = tmp[33:0];
      d   = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom_range(0, 1)));
      else
        do_read(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), d, 2'($urandom),
                $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
